// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store sequencer between the core pipeline and a single-word memory port.
// Latency: 2 cycles minimum (accept, memory ack, done pulse); illegal/misaligned reported 1 cycle after request.
// Backpressure: stall_o holds the core while an access is in flight; memory paces via mem_ack_i, bounded by TIMEOUT.
//
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   req_i, we_i, funct3_i, addr_i,       core request; operands held stable until a completion pulse
//   wdata_i
//   rdata_o, done_o, err_o, misalign_o   formatted load data and one-cycle completion pulses
//   stall_o                              combinational hold for the core pipeline
//   mem_req_o, mem_we_o, mem_addr_o,     word-aligned memory request, held until ack or timeout
//   mem_be_o, mem_wdata_o
//   mem_rdata_i, mem_ack_i               memory read word and one-cycle completion
module load_store_unit #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_i,
    input  logic         we_i,
    input  logic [2:0]   funct3_i,
    input  logic [N-1:0] addr_i,
    input  logic [N-1:0] wdata_i,
    output logic [N-1:0] rdata_o,
    output logic         done_o,
    output logic         err_o,
    output logic         misalign_o,
    output logic         stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [N-1:0] mem_addr_o,
    output logic [3:0]   mem_be_o,
    output logic [N-1:0] mem_wdata_o,
    input  logic [N-1:0] mem_rdata_i,
    input  logic         mem_ack_i
);

    typedef enum logic [2:0] {IDLE, BUSY, DONE, FAIL, MIS} state_t;

    // Last BUSY cycle index before giving up on the memory.
    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic         illegal;
    logic         misaligned;
    logic [3:0]   be_next;
    logic [N-1:0] wdata_next;
    logic [N-1:0] lane;
    logic [N-1:0] load_data;

    // Reserved encodings, plus unsigned variants which only exist for loads.
    assign illegal    = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) || (we_i && funct3_i[2]);
    assign misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = wdata_i;
        if (we_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    be_next    = 4'b0001 << addr_i[1:0];
                    wdata_next = {4{wdata_i[7:0]}};
                end
                2'b01: begin
                    be_next    = 4'b0011 << {addr_i[1], 1'b0};
                    wdata_next = {2{wdata_i[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = wdata_i;
                end
            endcase
        end
    end

    // Shift the addressed lane down to bit 0, then extend by access type.
    assign lane = mem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        load_data = lane;
        case (funct3_q)
            3'b000:  load_data = {{(N-8){lane[7]}}, lane[7:0]};
            3'b100:  load_data = {{(N-8){1'b0}}, lane[7:0]};
            3'b001:  load_data = {{(N-16){lane[15]}}, lane[15:0]};
            3'b101:  load_data = {{(N-16){1'b0}}, lane[15:0]};
            default: load_data = mem_rdata_i;
        endcase
    end

    assign stall_o = req_i & ~(done_o | err_o | misalign_o);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            rdata_o     <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            misalign_o  <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
        end else begin
            // Completion outputs are pulses; rdata_o is only non-zero in DONE.
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            misalign_o <= 1'b0;
            rdata_o    <= '0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        if (illegal) begin
                            state <= FAIL;
                            err_o <= 1'b1;
                        end else if (misaligned) begin
                            state      <= MIS;
                            misalign_o <= 1'b1;
                        end else begin
                            state       <= BUSY;
                            wait_cnt    <= '0;
                            funct3_q    <= funct3_i;
                            off_q       <= addr_i[1:0];
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= we_i;
                            mem_addr_o  <= {addr_i[N-1:2], 2'b00};
                            mem_be_o    <= be_next;
                            mem_wdata_o <= wdata_next;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack_i || (wait_cnt == TMAX)) begin
                        if (mem_ack_i) begin
                            state   <= DONE;
                            done_o  <= 1'b1;
                            rdata_o <= mem_we_o ? '0 : load_data;
                        end else begin
                            state <= FAIL;
                            err_o <= 1'b1;
                        end
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= '0;
                        mem_be_o    <= '0;
                        mem_wdata_o <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE, FAIL, MIS: state <= IDLE;
                default:         state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk_i;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        err_o;
    logic        misalign_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    int vectors;
    int miscompares;

    load_store_unit #(.N(32), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o),
        .misalign_o(misalign_o), .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // What one request looked like from the outside.
    typedef struct {
        int          kind;     // 0 none, 1 done, 2 err, 3 misalign, 4 several pulses at once
        int          cyc;      // cycle of the completion pulse, request presented in cycle 0
        logic [31:0] rdata;
        int          nreq;     // cycles with mem_req_o high
        logic        m_we;
        logic [31:0] m_addr;
        logic [3:0]  m_be;
        logic [31:0] m_wdata;
        bit          stable;
        bit          stall_ok;
        bit          idle_clean;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic int m_kind(input logic we, input logic [2:0] f3, input logic [31:0] a, input int d);
        if (f3 == 3 || f3 == 6 || f3 == 7 || (we && f3 >= 4)) return 2;
        if (((f3 == 1 || f3 == 5) && a[0]) || (f3 == 2 && a % 4 != 0)) return 3;
        if (d >= TO) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int off;
        logic [7:0]  b;
        logic [15:0] h;
        off = int'(a % 4);
        b = w[8*off +: 8];
        h = w[16*(off/2) +: 16];
        case (f3)
            3'd0: return b[7] ? (32'hFFFFFF00 | 32'(b)) : 32'(b);
            3'd4: return 32'(b);
            3'd1: return h[15] ? (32'hFFFF0000 | 32'(h)) : 32'(h);
            3'd5: return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] r;
        r = 4'b1111;
        if (we && f3 == 0) begin
            r = 4'b0000;
            r[a % 4] = 1'b1;
        end else if (we && f3 == 1) begin
            r = (a % 4 >= 2) ? 4'b1100 : 4'b0011;
        end
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 4; i++) begin
            if (f3 == 0) r[8*i +: 8] = w[7:0];
            else if (f3 == 1) r[8*i +: 8] = w[8*(i % 2) +: 8];
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int d, output obs_t o);
        o.kind = 0; o.cyc = 0; o.rdata = '0; o.nreq = 0; o.m_we = 0; o.m_addr = '0;
        o.m_be = '0; o.m_wdata = '0; o.stable = 1; o.stall_ok = 1; o.idle_clean = 0;
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
        for (int c = 1; c <= 40 && o.kind == 0; c++) begin
            @(negedge clk_i);
            mem_ack_i   = 1'b0;
            mem_rdata_i = $urandom;
            if (done_o || err_o || misalign_o) begin
                o.kind  = (int'(done_o) + int'(err_o) + int'(misalign_o) > 1) ? 4 :
                          done_o ? 1 : err_o ? 2 : 3;
                o.cyc   = c;
                o.rdata = rdata_o;
                if (stall_o !== 1'b0) o.stall_ok = 0;
            end else if (stall_o !== 1'b1) begin
                o.stall_ok = 0;
            end
            if (mem_req_o) begin
                o.nreq++;
                if (o.nreq == 1) begin
                    o.m_we = mem_we_o; o.m_addr = mem_addr_o; o.m_be = mem_be_o; o.m_wdata = mem_wdata_o;
                end else if (mem_we_o !== o.m_we || mem_addr_o !== o.m_addr ||
                             mem_be_o !== o.m_be || mem_wdata_o !== o.m_wdata) begin
                    o.stable = 0;
                end
                if (o.nreq == d + 1) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = rd;
                end
            end
        end
        req_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk_i);
        o.idle_clean = (done_o === 1'b0 && err_o === 1'b0 && misalign_o === 1'b0 && stall_o === 1'b0 &&
                        mem_req_o === 1'b0 && rdata_o === 32'h0 && mem_be_o === 4'h0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b010; addr_i = '0; wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(negedge clk_i);
        vectors++;
        if ({done_o, err_o, misalign_o, stall_o, mem_req_o, mem_we_o} !== 6'b0 ||
            rdata_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_be_o !== 4'h0 || mem_wdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got pulses=%b req=%b rdata=%h be=%h, expected all zero",
                     {done_o, err_o, misalign_o}, mem_req_o, rdata_o, mem_be_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_directed();
        obs_t o;
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, o);
        vectors++; if (o.kind !== 1 || o.cyc !== 2) begin miscompares++;
            $display("FAIL lw_latency: got kind %0d cycle %0d, expected kind 1 cycle 2", o.kind, o.cyc); end
        vectors++; if (o.rdata !== 32'hDEADBEEF) begin miscompares++;
            $display("FAIL lw_rdata: got %h expected deadbeef", o.rdata); end
        vectors++; if (o.m_addr !== 32'h100 || o.m_be !== 4'b1111 || o.m_we !== 1'b0) begin miscompares++;
            $display("FAIL lw_mem: got addr %h be %b we %b expected 00000100 1111 0", o.m_addr, o.m_be, o.m_we); end

        run_op(1'b0, 3'b000, 32'h203, 32'h0, 32'h80112233, 1, o);
        vectors++; if (o.rdata !== 32'hFFFFFF80) begin miscompares++;
            $display("FAIL lb_sign: got %h expected ffffff80", o.rdata); end
        run_op(1'b0, 3'b100, 32'h203, 32'h0, 32'h80112233, 0, o);
        vectors++; if (o.rdata !== 32'h00000080) begin miscompares++;
            $display("FAIL lbu_zero: got %h expected 00000080", o.rdata); end
        run_op(1'b0, 3'b101, 32'h202, 32'h0, 32'h80112233, 0, o);
        vectors++; if (o.rdata !== 32'h00008011) begin miscompares++;
            $display("FAIL lhu_zero: got %h expected 00008011", o.rdata); end

        run_op(1'b1, 3'b000, 32'h11, 32'h000000A5, 32'h12345678, 0, o);
        vectors++; if (o.m_be !== 4'b0010 || o.m_wdata !== 32'hA5A5A5A5 || o.m_we !== 1'b1) begin miscompares++;
            $display("FAIL sb_mem: got be %b wdata %h we %b expected 0010 a5a5a5a5 1", o.m_be, o.m_wdata, o.m_we); end
        vectors++; if (o.rdata !== 32'h0 || o.kind !== 1) begin miscompares++;
            $display("FAIL sb_rdata: got kind %0d rdata %h expected 1 00000000", o.kind, o.rdata); end
        run_op(1'b1, 3'b001, 32'h12, 32'h0000BEEF, 32'h0, 0, o);
        vectors++; if (o.m_be !== 4'b1100 || o.m_wdata !== 32'hBEEFBEEF) begin miscompares++;
            $display("FAIL sh_mem: got be %b wdata %h expected 1100 beefbeef", o.m_be, o.m_wdata); end

        run_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, o);
        vectors++; if (o.kind !== 3 || o.cyc !== 1 || o.nreq !== 0) begin miscompares++;
            $display("FAIL lw_misalign: got kind %0d cycle %0d memreq %0d expected 3 1 0", o.kind, o.cyc, o.nreq); end
        run_op(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, o);
        vectors++; if (o.kind !== 2 || o.cyc !== 1 || o.nreq !== 0) begin miscompares++;
            $display("FAIL illegal_f3: got kind %0d cycle %0d memreq %0d expected 2 1 0", o.kind, o.cyc, o.nreq); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_op(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1000, o);
        vectors++; if (o.nreq !== TO || o.kind !== 2 || o.cyc !== TO + 1) begin miscompares++;
            $display("FAIL timeout: got memreq %0d kind %0d cycle %0d expected %0d 2 %0d", o.nreq, o.kind, o.cyc, TO, TO + 1); end
        vectors++; if (!o.idle_clean || !o.stable) begin miscompares++;
            $display("FAIL timeout_idle: got clean %0d stable %0d expected 1 1", o.idle_clean, o.stable); end
    endtask

    task automatic test_reset_busy();
        obs_t o;
        int seen;
        seen = 0;
        req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h300; wdata_i = '0;
        for (int c = 0; c < 10 && seen < 3; c++) begin
            @(negedge clk_i);
            if (mem_req_o) seen++;
        end
        vectors++; if (seen !== 3) begin miscompares++;
            $display("FAIL rst_busy_setup: got %0d busy cycles expected 3", seen); end
        rst_i = 1'b1; req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        vectors++; if (mem_req_o !== 1'b0 || done_o !== 1'b0) begin miscompares++;
            $display("FAIL rst_busy_clear: got req %b done %b expected 0 0", mem_req_o, done_o); end
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        vectors++; if (done_o !== 1'b0 || err_o !== 1'b0 || mem_req_o !== 1'b0 || rdata_o !== 32'h0) begin miscompares++;
            $display("FAIL rst_late_ack: got done %b err %b req %b rdata %h expected 0 0 0 0",
                     done_o, err_o, mem_req_o, rdata_o); end
        run_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h01020304, 0, o);
        vectors++; if (o.kind !== 1 || o.cyc !== 2 || o.rdata !== 32'h01020304) begin miscompares++;
            $display("FAIL rst_then_idle: got kind %0d cycle %0d rdata %h expected 1 2 01020304", o.kind, o.cyc, o.rdata); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [2:0]  f3_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd0, 3'd3, 3'd6, 3'd7};
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, wd, rd, exp_rd;
        int          d, ek, ecyc, enreq;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = f3_tab[$urandom_range(0, 9)];
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wd = $urandom; rd = $urandom;
            d  = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
            run_op(we, f3, a, wd, rd, d, o);
            ek     = m_kind(we, f3, a, d);
            ecyc   = (ek == 1) ? d + 2 : (ek == 2 && d >= TO && m_kind(we, f3, a, 0) == 1) ? TO + 1 : 1;
            enreq  = (ek == 1) ? d + 1 : (ecyc == TO + 1) ? TO : 0;
            exp_rd = (ek == 1 && !we) ? m_load(f3, a, rd) : 32'h0;
            vectors++; if (o.kind !== ek || o.cyc !== ecyc || o.nreq !== enreq) begin miscompares++;
                $display("FAIL rnd%0d_flow: we %b f3 %0d addr %h: got kind %0d cyc %0d memreq %0d expected %0d %0d %0d",
                         i, we, f3, a, o.kind, o.cyc, o.nreq, ek, ecyc, enreq); end
            vectors++; if (o.rdata !== exp_rd) begin miscompares++;
                $display("FAIL rnd%0d_rdata: f3 %0d addr %h word %h: got %h expected %h", i, f3, a, rd, o.rdata, exp_rd); end
            if (enreq > 0) begin
                vectors++;
                if (o.m_we !== we || o.m_addr !== (a & 32'hFFFFFFFC) || o.m_be !== m_be(we, f3, a) ||
                    (we && o.m_wdata !== m_wdata(f3, wd)) || !o.stable) begin
                    miscompares++;
                    $display("FAIL rnd%0d_mem: got we %b addr %h be %b wdata %h stable %0d expected %b %h %b %h 1",
                             i, o.m_we, o.m_addr, o.m_be, o.m_wdata, o.stable, we, a & 32'hFFFFFFFC,
                             m_be(we, f3, a), m_wdata(f3, wd));
                end
            end
            vectors++; if (!o.stall_ok || !o.idle_clean) begin miscompares++;
                $display("FAIL rnd%0d_stall_idle: got stall_ok %0d idle_clean %0d expected 1 1", i, o.stall_ok, o.idle_clean); end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_timeout();
        test_reset_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter N, default 32, datapath width; only N=32 is supported.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum wait cycles for mem_ack_i; legal range 2..255.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 req_i  in  1  core requests a memory operation; core holds req_i and operands stable until done_o, err_o or misalign_o.
REQ-006 we_i  in  1  1=store, 0=load.
REQ-007 funct3_i  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-008 addr_i  in  N  effective byte address, from the ALU result.
REQ-009 wdata_i  in  N  store data (rs2).
REQ-010 rdata_o  out  N  formatted load data, valid while done_o=1.
REQ-011 done_o  out  1  one-cycle completion pulse.
REQ-012 err_o  out  1  one-cycle pulse: timeout or illegal funct3.
REQ-013 misalign_o  out  1  one-cycle pulse: misaligned address, no memory access made.
REQ-014 stall_o  out  1  combinational: req_i & ~(done_o|err_o|misalign_o).
REQ-015 mem_req_o  out  1  memory request, held until mem_ack_i or timeout.
REQ-016 mem_we_o  out  1  memory write enable.
REQ-017 mem_addr_o  out  N  word-aligned address {addr[N-1:2],2'b00}.
REQ-018 mem_be_o  out  4  byte enables.
REQ-019 mem_wdata_o  out  N  lane-replicated store data.
REQ-020 mem_rdata_i  in  N  memory read word, valid with mem_ack_i.
REQ-021 mem_ack_i  in  1  memory completion, one-cycle pulse.

Function
REQ-022 FSM states SHALL be IDLE, BUSY, DONE, FAIL, MIS.
REQ-023 IDLE with req_i=1: illegal funct3 (011, 110, 111, or store with funct3[2]=1) -> FAIL; misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0) -> MIS; otherwise latch we, funct3, addr, wdata -> BUSY.
REQ-024 BUSY SHALL drive mem_req_o=1 with mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o from latched values, stable every cycle.
REQ-025 BUSY with mem_ack_i=1 -> DONE and capture formatted read data; BUSY wait counter reaching TIMEOUT-1 without ack -> FAIL.
REQ-026 DONE, FAIL and MIS SHALL each last exactly one cycle, assert done_o, err_o or misalign_o respectively, then return to IDLE; req_i is ignored in these states.
REQ-027 Minimum latency: accept in cycle 0, ack in cycle 1, done_o in cycle 2.
REQ-028 Store byte enables: B 4'b0001<<addr[1:0]; H 4'b0011<<{addr[1],1'b0}; W 4'b1111; loads drive mem_be_o=4'b1111.
REQ-029 Store data: B {4{wdata[7:0]}}; H {2{wdata[15:0]}}; W wdata.
REQ-030 Load: select byte/half lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-031 rdata_o SHALL be 0 on store completion and in every state other than DONE.
REQ-032 mem_ack_i outside BUSY SHALL be ignored.
REQ-033 Wait counter SHALL clear on entry to BUSY and never wrap.

Reset
REQ-034 rst_i=1 SHALL force IDLE, counter 0, and all outputs 0 (including mem_req_o) at the next edge, including mid-BUSY; a late mem_ack_i after reset is ignored.

Verification
REQ-035 LW addr 0x100, ack in cycle 1 with mem_rdata_i 0xDEADBEEF -> done_o in cycle 2, rdata_o 0xDEADBEEF, mem_addr_o 0x100, mem_be_o 4'b1111.
REQ-036 LB addr 0x203, mem_rdata_i 0x80112233 -> rdata_o 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x202 -> 0x00008011.
REQ-037 SB addr 0x11, wdata 0x000000A5 -> mem_be_o 4'b0010, mem_wdata_o 0xA5A5A5A5, mem_we_o 1; SH addr 0x12 -> mem_be_o 4'b1100.
REQ-038 LW addr 0x102 -> misalign_o in cycle 1, mem_req_o never asserted; funct3 011 -> err_o in cycle 1.
REQ-039 No ack, TIMEOUT=16 -> mem_req_o high 16 cycles, then err_o pulse, then IDLE.
REQ-040 rst_i in the 3rd BUSY cycle, ack one cycle later -> mem_req_o 0, no done_o, state IDLE.
